// File: rtl/store_rmw_sequencer_pkg.sv
// Shared store encodings, sequencer state type and big-endian lane helpers
// for the store read-modify-write sequencer.
package store_pkg;

  localparam logic [1:0] ST_NONE = 2'd0;
  localparam logic [1:0] ST_WORD = 2'd1;
  localparam logic [1:0] ST_BYTE = 2'd2;
  localparam logic [1:0] ST_HALF = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    WRITE,
    RETIRE
  } state_t;

  localparam logic [31:0] BYTE_LANE_MASK = 32'h0000_00FF;
  localparam logic [31:0] HALF_LANE_MASK = 32'h0000_FFFF;

  // Big-endian: byte offset 0 lives in [31:24], so the shift is (3-off)*8.
  function automatic logic [4:0] lane_shift(input logic [1:0] off);
    return {~off, 3'b000};
  endfunction

endpackage

// File: rtl/store_rmw_sequencer_lane_merge.sv
// Combinational merge of store data into its big-endian lane of a memory word.
module store_lane_merge
  import store_pkg::*;
(
  input  logic [1:0]  op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] new_word_o
);

  logic [31:0] mask;
  logic [31:0] lane;

  always_comb begin
    mask       = '0;
    lane       = '0;
    new_word_o = old_word_i;
    case (op_i)
      ST_WORD: new_word_o = wdata_i;
      ST_BYTE: begin
        mask       = BYTE_LANE_MASK << lane_shift(off_i);
        lane       = {24'd0, wdata_i[7:0]} << lane_shift(off_i);
        new_word_o = (old_word_i & ~mask) | (lane & mask);
      end
      ST_HALF: begin
        // A halfword occupies the lane of its odd byte: offset 0 -> [31:16], 2 -> [15:0].
        mask       = HALF_LANE_MASK << lane_shift({off_i[1], 1'b1});
        lane       = {16'd0, wdata_i[15:0]} << lane_shift({off_i[1], 1'b1});
        new_word_o = (old_word_i & ~mask) | (lane & mask);
      end
      default: new_word_o = old_word_i;
    endcase
  end

endmodule

// File: rtl/store_rmw_sequencer.sv
// Store sequencer: SW writes through, SB/SH read the word, merge the lane and
// write it back. One request in flight; all outputs registered.
module store_rmw_sequencer
  import store_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rdata,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic              err_misalign
);

  localparam logic [1:0] CNT_INIT = 2'(RD_LATENCY - 1);

  state_t            state_q;
  logic              ready_q;
  logic              rd_en_q;
  logic              wr_en_q;
  logic              done_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       mem_wdata_q;

  logic [1:0]        op_q;
  logic [1:0]        off_q;
  logic [31:0]       wdata_q;
  logic [1:0]        cnt_q;

  logic              xfer;
  logic              needs_rmw;
  logic [31:0]       merge_d;

  assign xfer      = req_valid & ready_q;
  assign needs_rmw = (req_op == ST_BYTE) || ((req_op == ST_HALF) && !req_addr[0]);

  store_lane_merge u_merge (
    .op_i       (op_q),
    .off_i      (off_q),
    .old_word_i (mem_rdata),
    .wdata_i    (wdata_q),
    .new_word_o (merge_d)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      mem_wdata_q <= '0;
    end else begin
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (xfer) begin
            ready_q <= 1'b0;
            addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
            if (req_op == ST_WORD) begin
              state_q     <= WRITE;
              wr_en_q     <= 1'b1;
              done_q      <= 1'b1;
              mem_wdata_q <= req_wdata;
            end else if (needs_rmw) begin
              state_q <= READ;
              rd_en_q <= 1'b1;
            end else begin
              // Only ST_HALF can fall through here misaligned; ST_NONE retires cleanly.
              state_q <= RETIRE;
              done_q  <= 1'b1;
              err_q   <= (req_op == ST_HALF);
            end
          end
        end
        READ: state_q <= WAIT;
        WAIT: begin
          if (cnt_q == 2'd0) begin
            state_q     <= WRITE;
            wr_en_q     <= 1'b1;
            done_q      <= 1'b1;
            mem_wdata_q <= merge_d;
          end
        end
        WRITE, RETIRE: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Request fields and the read-wait counter need no reset: always loaded before use.
  always_ff @(posedge Clk) begin
    if (xfer) begin
      op_q    <= req_op;
      off_q   <= req_addr[1:0];
      wdata_q <= req_wdata;
    end
    if (state_q == READ) begin
      cnt_q <= CNT_INIT;
    end else if ((state_q == WAIT) && (cnt_q != 2'd0)) begin
      cnt_q <= cnt_q - 2'd1;
    end
  end

  assign req_ready    = ready_q;
  assign mem_addr     = addr_q;
  assign mem_rd_en    = rd_en_q;
  assign mem_wr_en    = wr_en_q;
  assign mem_wdata    = mem_wdata_q;
  assign done         = done_q;
  assign err_misalign = err_q;

endmodule

// File: tb/tb_store_rmw_sequencer.sv
// Scoreboard bench for store_rmw_sequencer: two instances (read latency 1 and 3)
// with a small memory model; expected strobe events are queued and checked on negedge.
module tb_store_rmw_sequencer;
  import store_pkg::*;

  typedef struct {
    int          cyc;
    bit          rd;
    bit          wr;
    bit          dn;
    bit          er;
    logic [31:0] addr;
    logic [31:0] wdata;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  logic        req_valid [2];
  logic        req_ready [2];
  logic [1:0]  req_op    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [31:0] mem_addr  [2];
  logic        mem_rd_en [2];
  logic [31:0] mem_rdata [2];
  logic        mem_wr_en [2];
  logic [31:0] mem_wdata [2];
  logic        done      [2];
  logic        err       [2];
  logic [31:0] mem_word  [2];

  ev_t q0[$];
  ev_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : gd
    localparam int L = (g == 0) ? 1 : 3;
    logic [3:0] rd_sh;

    store_rmw_sequencer #(.ADDR_W(32), .RD_LATENCY(L)) u_dut (
      .Clk          (clk),
      .Reset        (rst_n),
      .req_valid    (req_valid[g]),
      .req_ready    (req_ready[g]),
      .req_op       (req_op[g]),
      .req_addr     (req_addr[g]),
      .req_wdata    (req_wdata[g]),
      .mem_addr     (mem_addr[g]),
      .mem_rd_en    (mem_rd_en[g]),
      .mem_rdata    (mem_rdata[g]),
      .mem_wr_en    (mem_wr_en[g]),
      .mem_wdata    (mem_wdata[g]),
      .done         (done[g]),
      .err_misalign (err[g])
    );

    // Read data is only meaningful in the single cycle L after the strobe.
    always @(posedge clk) begin
      if (!rst_n) rd_sh <= 4'd0;
      else        rd_sh <= {rd_sh[2:0], mem_rd_en[g]};
    end
    assign mem_rdata[g] = rd_sh[L-1] ? mem_word[g] : 32'hA5A5_A5A5;
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction

  function automatic ev_t mk(input int c, input bit rd, input bit wr, input bit dn, input bit er,
                             input logic [31:0] a, input logic [31:0] w);
    ev_t e;
    e.cyc = c; e.rd = rd; e.wr = wr; e.dn = dn; e.er = er; e.addr = a; e.wdata = w;
    return e;
  endfunction

  function automatic void push(input int g, input ev_t e);
    if (g == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  function automatic void pop(input int g, output ev_t e, output bit ok);
    ok = 1'b0;
    e  = mk(0, 0, 0, 0, 0, 0, 0);
    if (g == 0 && q0.size() != 0) begin e = q0.pop_front(); ok = 1'b1; end
    if (g == 1 && q1.size() != 0) begin e = q1.pop_front(); ok = 1'b1; end
  endfunction

  function automatic int qsize(input int g);
    return (g == 0) ? q0.size() : q1.size();
  endfunction

  // Monitor: every strobe/done cycle must match the next queued event exactly.
  always @(negedge clk) begin
    ev_t e;
    bit  ok;
    for (int g = 0; g < 2; g++) begin
      if (rst_n && (mem_rd_en[g] | mem_wr_en[g] | done[g] | err[g])) begin
        pop(g, e, ok);
        if (!ok) begin
          n_chk++;
          $display("FAIL unexpected_event d%0d cyc %0d: got rd%0b wr%0b done%0b err%0b required none",
                   g, cyc, mem_rd_en[g], mem_wr_en[g], done[g], err[g]);
        end else begin
          chk($sformatf("event_cycle d%0d", g), cyc, e.cyc);
          chk($sformatf("strobes{rd,wr,done,err} d%0d cyc%0d", g, cyc),
              {28'd0, mem_rd_en[g], mem_wr_en[g], done[g], err[g]},
              {28'd0, e.rd, e.wr, e.dn, e.er});
          chk($sformatf("mem_addr d%0d cyc%0d", g, cyc), mem_addr[g], e.addr);
          if (e.wr) chk($sformatf("mem_wdata d%0d cyc%0d", g, cyc), mem_wdata[g], e.wdata);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int g);
    for (int i = 0; i < 20 && qsize(g) != 0; i++) tick();
    if (qsize(g) != 0) begin
      n_chk++;
      $display("FAIL timeout d%0d: got %0d pending events required 0", g, qsize(g));
    end
  endtask

  // Issues one request; expected write data is hand-computed by the caller.
  task automatic issue(input int g, input logic [1:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] memw, input logic [31:0] expw,
                       output int t);
    int          lat;
    logic [31:0] wa;
    lat = (g == 0) ? 1 : 3;
    wa  = {addr[31:2], 2'b00};
    chk($sformatf("ready_before_issue d%0d", g), {31'd0, req_ready[g]}, 32'd1);
    mem_word[g] = memw;
    req_valid[g] = 1'b1; req_op[g] = op; req_addr[g] = addr; req_wdata[g] = wd;
    t = cyc;
    if (op == ST_WORD) begin
      push(g, mk(t + 1, 0, 1, 1, 0, wa, expw));
    end else if (op == ST_BYTE || (op == ST_HALF && !addr[0])) begin
      push(g, mk(t + 1, 1, 0, 0, 0, wa, 32'd0));
      push(g, mk(t + 2 + lat, 0, 1, 1, 0, wa, expw));
    end else begin
      push(g, mk(t + 1, 0, 0, 1, (op == ST_HALF), wa, 32'd0));
    end
    tick();
    req_valid[g] = 1'b0; req_op[g] = ST_NONE;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2;
    rst_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      req_valid[g] = 1'b0; req_op[g] = ST_NONE; req_addr[g] = '0; req_wdata[g] = '0;
      mem_word[g] = '0;
    end
    repeat (3) tick();
    rst_n = 1'b1;

    for (int g = 0; g < 2; g++) begin
      chk($sformatf("reset_ready d%0d", g), {31'd0, req_ready[g]}, 32'd1);
      chk($sformatf("reset_strobes d%0d", g),
          {28'd0, mem_rd_en[g], mem_wr_en[g], done[g], err[g]}, 32'd0);
      chk($sformatf("reset_mem_addr d%0d", g), mem_addr[g], 32'd0);
      chk($sformatf("reset_mem_wdata d%0d", g), mem_wdata[g], 32'd0);
    end

    // Reset during WAIT of an SB: the read happens, the write must never appear.
    mem_word[0] = 32'h1122_3344;
    req_valid[0] = 1'b1; req_op[0] = ST_BYTE; req_addr[0] = 32'h104; req_wdata[0] = 32'hEE;
    t = cyc;
    push(0, mk(t + 1, 1, 0, 0, 0, 32'h104, 32'd0));
    tick();
    req_valid[0] = 1'b0; req_op[0] = ST_NONE;
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("ready_after_midflight_reset", {31'd0, req_ready[0]}, 32'd1);
    chk("strobes_after_midflight_reset",
        {28'd0, mem_rd_en[0], mem_wr_en[0], done[0], err[0]}, 32'd0);
    chk("mem_addr_after_midflight_reset", mem_addr[0], 32'd0);
    repeat (6) tick();

    issue(0, ST_WORD, 32'h100, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, t);       wait_idle(0);
    issue(0, ST_BYTE, 32'h103, 32'h0000_00AA, 32'h1122_3344, 32'h1122_33AA, t); wait_idle(0);
    issue(0, ST_BYTE, 32'h100, 32'hFFFF_FF77, 32'h1122_3344, 32'h7722_3344, t); wait_idle(0);
    issue(0, ST_BYTE, 32'h101, 32'h0000_0077, 32'h1122_3344, 32'h1177_3344, t); wait_idle(0);
    issue(0, ST_HALF, 32'h202, 32'h0000_BEEF, 32'hCAFE_1234, 32'hCAFE_BEEF, t); wait_idle(0);
    issue(0, ST_HALF, 32'h200, 32'h1111_BEEF, 32'hCAFE_1234, 32'hBEEF_1234, t); wait_idle(0);
    issue(0, ST_NONE, 32'h300, 32'h0, 32'h0, 32'h0, t);                          wait_idle(0);

    // Misaligned half retires alone; the next request goes in two cycles after transfer.
    issue(0, ST_HALF, 32'h201, 32'h0000_BEEF, 32'hCAFE_1234, 32'h0, t);
    wait_idle(0);
    chk("back_to_back_accept_cycle", cyc, t + 2);
    issue(0, ST_WORD, 32'h206, 32'h1234_5678, 32'h0, 32'h1234_5678, t2);
    wait_idle(0);

    // Latency 3 with req_valid held: busy-time requests are ignored.
    mem_word[1] = 32'h0000_0000;
    req_valid[1] = 1'b1; req_op[1] = ST_BYTE; req_addr[1] = 32'h10; req_wdata[1] = 32'h55;
    t = cyc;
    push(1, mk(t + 1, 1, 0, 0, 0, 32'h10, 32'd0));
    push(1, mk(t + 5, 0, 1, 1, 0, 32'h10, 32'h5500_0000));
    push(1, mk(t + 7, 0, 0, 1, 0, 32'h20, 32'd0));
    tick();
    req_op[1] = ST_NONE; req_addr[1] = 32'h20;
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("lat3_ready_low T+%0d", k), {31'd0, req_ready[1]}, 32'd0);
      tick();
    end
    chk("lat3_ready_T+6", {31'd0, req_ready[1]}, 32'd1);
    tick();
    req_valid[1] = 1'b0;
    wait_idle(1);

    repeat (4) tick();
    chk("final_queue_d0", q0.size(), 32'd0);
    chk("final_queue_d1", q1.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
